mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of one shared block memory.
// One transaction at a time; every output comes straight from a register.
module mem_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read_I,
  input  logic          mem_write_I,
  input  logic [31:4]   mem_addr_I,
  input  logic [127:0]  mem_wdata_I,
  output logic [127:0]  mem_rdata_I,
  output logic          mem_ready_I,
  input  logic          mem_read_D,
  input  logic          mem_write_D,
  input  logic [31:4]   mem_addr_D,
  input  logic [127:0]  mem_wdata_D,
  output logic [127:0]  mem_rdata_D,
  output logic          mem_ready_D,
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:4]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic [127:0]  mem_rdata,
  input  logic          mem_ready
);
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           grant_q, grant_d;
  logic           mem_read_q, mem_read_d;
  logic           mem_write_q, mem_write_d;
  logic [31:4]    mem_addr_q, mem_addr_d;
  logic [127:0]   mem_wdata_q, mem_wdata_d;
  logic [127:0]   rbuf_q, rbuf_d;
  logic           ready_I_q, ready_I_d;
  logic           ready_D_q, ready_D_d;

  logic req_I, req_D, sel;

  assign req_I = mem_read_I | mem_write_I;
  assign req_D = mem_read_D | mem_write_D;

  // On a tie, round-robin hands the grant to whichever side did not win last.
  always_comb begin
    sel = GNT_I;
    if (req_I && req_D)
      sel = (RR_EN != 0) ? ~last_grant_q : GNT_D;
    else if (req_D)
      sel = GNT_D;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      grant_q      <= GNT_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rbuf_q       <= '0;
      ready_I_q    <= 1'b0;
      ready_D_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rbuf_q       <= rbuf_d;
      ready_I_q    <= ready_I_d;
      ready_D_q    <= ready_D_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_I || req_D) state_d = BUSY;
      BUSY:    if (mem_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready strobes default low so each completion produces a single-cycle pulse.
  always_comb begin
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rbuf_d       = rbuf_q;
    ready_I_d    = 1'b0;
    ready_D_d    = 1'b0;
    case (state_q)
      IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (req_I || req_D) begin
          grant_d      = sel;
          last_grant_d = sel;
          mem_read_d   = (sel == GNT_D) ? mem_read_D  : mem_read_I;
          mem_write_d  = (sel == GNT_D) ? mem_write_D : mem_write_I;
          mem_addr_d   = (sel == GNT_D) ? mem_addr_D  : mem_addr_I;
          mem_wdata_d  = (sel == GNT_D) ? mem_wdata_D : mem_wdata_I;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          rbuf_d      = mem_rdata;
          ready_I_d   = (grant_q == GNT_I);
          ready_D_d   = (grant_q == GNT_D);
        end
      end
      default: ;
    endcase
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_rdata_I = rbuf_q;
  assign mem_rdata_D = rbuf_q;
  assign mem_ready_I = ready_I_q;
  assign mem_ready_D = ready_D_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin and a fixed-priority instance
// share the same stimulus; checks run on the falling edge.
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd_I, wr_I, rd_D, wr_D;
  logic [31:4]  addr_I, addr_D;
  logic [127:0] wdata_I, wdata_D;
  logic [127:0] mrdata;
  logic         mready;

  logic [127:0] r1_rdata_I, r1_rdata_D, r1_wdata, r0_rdata_I, r0_rdata_D, r0_wdata;
  logic         r1_ready_I, r1_ready_D, r1_read, r1_write;
  logic         r0_ready_I, r0_ready_D, r0_read, r0_write;
  logic [31:4]  r1_addr, r0_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RR_EN(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .mem_read_I(rd_I), .mem_write_I(wr_I), .mem_addr_I(addr_I), .mem_wdata_I(wdata_I),
    .mem_rdata_I(r1_rdata_I), .mem_ready_I(r1_ready_I),
    .mem_read_D(rd_D), .mem_write_D(wr_D), .mem_addr_D(addr_D), .mem_wdata_D(wdata_D),
    .mem_rdata_D(r1_rdata_D), .mem_ready_D(r1_ready_D),
    .mem_read(r1_read), .mem_write(r1_write), .mem_addr(r1_addr), .mem_wdata(r1_wdata),
    .mem_rdata(mrdata), .mem_ready(mready)
  );

  mem_arbiter #(.RR_EN(0)) dut_fix (
    .clk(clk), .rst_n(rst_n),
    .mem_read_I(rd_I), .mem_write_I(wr_I), .mem_addr_I(addr_I), .mem_wdata_I(wdata_I),
    .mem_rdata_I(r0_rdata_I), .mem_ready_I(r0_ready_I),
    .mem_read_D(rd_D), .mem_write_D(wr_D), .mem_addr_D(addr_D), .mem_wdata_D(wdata_D),
    .mem_rdata_D(r0_rdata_D), .mem_ready_D(r0_ready_D),
    .mem_read(r0_read), .mem_write(r0_write), .mem_addr(r0_addr), .mem_wdata(r0_wdata),
    .mem_rdata(mrdata), .mem_ready(mready)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd_I = 0; wr_I = 0; rd_D = 0; wr_D = 0;
    addr_I = '0; addr_D = '0; wdata_I = '0; wdata_D = '0;
    mrdata = '0; mready = 0;
    tick(); tick();
    checks++;
    if ({r1_read, r1_write, r1_ready_I, r1_ready_D, r0_read, r0_write, r0_ready_I, r0_ready_D} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {r1_read, r1_write, r1_ready_I, r1_ready_D, r0_read, r0_write, r0_ready_I, r0_ready_D});
    end
    checks++;
    if (r1_addr !== 28'h0 || r1_wdata !== 128'h0 || r1_rdata_I !== 128'h0 || r1_rdata_D !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata_I=%h want all zero", r1_addr, r1_wdata, r1_rdata_I);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    logic [127:0] a5;
    a5 = {4{32'hA5A5A5A5}};
    rd_I = 1; addr_I = 28'h0000010;
    tick();
    checks++;
    if (r1_read !== 1'b1 || r1_write !== 1'b0 || r1_addr !== 28'h0000010) begin
      errors++;
      $display("FAIL single_req_c1: read=%b write=%b addr=%h want 1 0 0000010", r1_read, r1_write, r1_addr);
    end
    tick(); tick(); tick();
    checks++;
    if (r1_read !== 1'b1 || r1_ready_I !== 1'b0) begin
      errors++;
      $display("FAIL single_hold_c4: read=%b ready_I=%b want 1 0", r1_read, r1_ready_I);
    end
    tick();
    mready = 1; mrdata = a5;
    tick();
    mready = 0; mrdata = '0;
    checks++;
    if (r1_ready_I !== 1'b1 || r1_rdata_I !== a5 || r1_ready_D !== 1'b0 || r1_read !== 1'b0) begin
      errors++;
      $display("FAIL single_resp_c6: ready_I=%b ready_D=%b read=%b rdata_I=%h want 1 0 0 %h",
               r1_ready_I, r1_ready_D, r1_read, r1_rdata_I, a5);
    end
    rd_I = 0;
    tick();
    checks++;
    if (r1_ready_I !== 1'b0 || r1_ready_D !== 1'b0 || r1_read !== 1'b0 || r1_rdata_I !== a5) begin
      errors++;
      $display("FAIL single_after_c7: ready_I=%b ready_D=%b read=%b rdata_I=%h want 0 0 0 %h",
               r1_ready_I, r1_ready_D, r1_read, r1_rdata_I, a5);
    end
  endtask

  task automatic test_arbitration();
    logic [31:4] exp_addr;
    logic        exp_d;
    rst_n = 0; tick(); rst_n = 1;
    rd_I = 1; addr_I = 28'h0000100;
    wr_D = 1; addr_D = 28'h0000200; wdata_D = {4{32'h12345678}};
    for (int t = 0; t < 4; t++) begin
      exp_d    = (t % 2 == 0);
      exp_addr = exp_d ? 28'h0000200 : 28'h0000100;
      tick();
      checks++;
      if (r1_addr !== exp_addr || r1_write !== exp_d || r1_read !== !exp_d) begin
        errors++;
        $display("FAIL rr_grant[%0d]: addr=%h write=%b read=%b want %h %b %b",
                 t, r1_addr, r1_write, r1_read, exp_addr, exp_d, !exp_d);
      end
      checks++;
      if (r0_addr !== 28'h0000200 || r0_write !== 1'b1 || r0_read !== 1'b0) begin
        errors++;
        $display("FAIL fix_grant[%0d]: addr=%h write=%b read=%b want 0000200 1 0",
                 t, r0_addr, r0_write, r0_read);
      end
      mready = 1; mrdata = 128'(t + 7);
      tick();
      mready = 0;
      checks++;
      if (r1_ready_D !== exp_d || r1_ready_I !== !exp_d || r1_rdata_D !== 128'(t + 7)) begin
        errors++;
        $display("FAIL rr_ready[%0d]: ready_D=%b ready_I=%b rdata=%h want %b %b %0d",
                 t, r1_ready_D, r1_ready_I, r1_rdata_D, exp_d, !exp_d, t + 7);
      end
      checks++;
      if (r0_ready_D !== 1'b1 || r0_ready_I !== 1'b0) begin
        errors++;
        $display("FAIL fix_ready[%0d]: ready_D=%b ready_I=%b want 1 0", t, r0_ready_D, r0_ready_I);
      end
      if (t == 3) begin rd_I = 0; wr_D = 0; end
      tick();
    end
  endtask

  task automatic test_drop_mid_busy();
    wr_D = 1; addr_D = 28'h0ABCDEF; wdata_D = {4{32'hCAFEF00D}};
    tick();
    wr_D = 0; wdata_D = '0; addr_D = '0;
    tick();
    checks++;
    if (r1_write !== 1'b1 || r1_addr !== 28'h0ABCDEF || r1_wdata !== {4{32'hCAFEF00D}}) begin
      errors++;
      $display("FAIL drop_hold: write=%b addr=%h wdata=%h want 1 0abcdef cafef00d..", r1_write, r1_addr, r1_wdata);
    end
    tick();
    mready = 1; mrdata = {4{32'h0BADBEEF}};
    tick();
    mready = 0;
    checks++;
    if (r1_ready_D !== 1'b1 || r1_ready_I !== 1'b0 || r1_write !== 1'b0 || r1_rdata_D !== {4{32'h0BADBEEF}}) begin
      errors++;
      $display("FAIL drop_ready: ready_D=%b ready_I=%b write=%b rdata=%h want 1 0 0 0badbeef..",
               r1_ready_D, r1_ready_I, r1_write, r1_rdata_D);
    end
    tick();
    checks++;
    if (r1_ready_D !== 1'b0 || r1_write !== 1'b0 || r1_read !== 1'b0) begin
      errors++;
      $display("FAIL drop_after: ready_D=%b write=%b read=%b want 0 0 0", r1_ready_D, r1_write, r1_read);
    end
  endtask

  task automatic test_read_write_both();
    rd_I = 1; wr_I = 1; addr_I = 28'h0000033; wdata_I = 128'h55;
    tick();
    rd_I = 0; wr_I = 0;
    checks++;
    if (r1_read !== 1'b1 || r1_write !== 1'b1 || r1_wdata !== 128'h55) begin
      errors++;
      $display("FAIL rw_forward: read=%b write=%b wdata=%h want 1 1 55", r1_read, r1_write, r1_wdata);
    end
    mready = 1; mrdata = 128'h99;
    tick();
    mready = 0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    rd_I = 1; addr_I = 28'h0000444;
    tick();
    checks++;
    if (r1_read !== 1'b1 || r1_addr !== 28'h0000444) begin
      errors++;
      $display("FAIL rstbusy_req: read=%b addr=%h want 1 0000444", r1_read, r1_addr);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (r1_read !== 1'b0 || r1_addr !== 28'h0 || r1_rdata_I !== 128'h0 || r1_ready_I !== 1'b0) begin
      errors++;
      $display("FAIL rstbusy_async: read=%b addr=%h rdata_I=%h ready_I=%b want 0 0 0 0",
               r1_read, r1_addr, r1_rdata_I, r1_ready_I);
    end
    rd_I = 0;
    tick();
    rst_n = 1; mready = 1; mrdata = 128'hFF;
    tick();
    mready = 0;
    checks++;
    if (r1_ready_I !== 1'b0 || r1_ready_D !== 1'b0 || r1_read !== 1'b0 || r1_rdata_I !== 128'h0) begin
      errors++;
      $display("FAIL rstbusy_late: ready_I=%b ready_D=%b read=%b rdata=%h want 0 0 0 0",
               r1_ready_I, r1_ready_D, r1_read, r1_rdata_I);
    end
  endtask

  task automatic test_idle_ready();
    mready = 1; mrdata = 128'h1234;
    tick();
    mready = 0;
    tick();
    checks++;
    if (r1_ready_I !== 1'b0 || r1_ready_D !== 1'b0 || r1_read !== 1'b0 || r1_write !== 1'b0 || r1_rdata_I !== 128'h0) begin
      errors++;
      $display("FAIL idle_ready: ready_I=%b ready_D=%b read=%b write=%b rdata=%h want 0 0 0 0 0",
               r1_ready_I, r1_ready_D, r1_read, r1_write, r1_rdata_I);
    end
    rd_D = 1; addr_D = 28'h0000777;
    tick();
    rd_D = 0;
    checks++;
    if (r1_read !== 1'b1 || r1_addr !== 28'h0000777) begin
      errors++;
      $display("FAIL idle_then_req: read=%b addr=%h want 1 0000777", r1_read, r1_addr);
    end
    mready = 1; tick(); mready = 0; tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_arbitration();
    test_drop_mid_busy();
    test_read_write_both();
    test_reset_mid_busy();
    test_idle_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
